alu_seq: RTL and testbench

//  Sequential ALU directly upstream of the accumulator: produces the 8-bit signed result Z
//  and the one-cycle LOAD_AC strobe that writes it into AC. Single-cycle for add/sub/logic/

---
 rtl/alu_seq_pkg.sv | 7 +
 rtl/alu_seq_if.sv | 16 +
 rtl/alu_seq_mul_iter.sv | 34 +++
 rtl/alu_seq.sv | 71 +++++++
 tb/tb_alu_seq.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared width, opcode and state types for the sequential ALU
package alu_seq_pkg;
  localparam int W = 8;
  localparam int MUL_CYCLES = W;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_ASR, OP_MUL} op_t;
  typedef enum logic {S_IDLE, S_MUL} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: control-unit side request (start/op/a/b) and ALU side result (z, load_ac, busy, flags)
interface alu_seq_if;
  import alu_seq_pkg::*;
  logic start;
  op_t op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] z;
  logic load_ac;
  logic busy;
  logic n_f;
  logic zero_f;
  logic v_f;
  modport master(output start, op, a, b, input z, load_ac, busy, n_f, zero_f, v_f);
  modport slave(input start, op, a, b, output z, load_ac, busy, n_f, zero_f, v_f);
endinterface

// File: rtl/alu_seq_mul_iter.sv
// alu_seq_mul_iter: shift-add magnitude multiplier; load captures ma/mb, each step adds one multiplier bit, prod is the post-step value
module alu_seq_mul_iter
  import alu_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W:0]     ma,
  input  logic [W:0]     mb,
  output logic [2*W-1:0] prod,
  output logic           done
);
  localparam int CW = $clog2(MUL_CYCLES);
  logic [2*W-1:0] acc, mc;
  logic [W:0] mp;
  logic [CW-1:0] cnt;
  // prod is combinational so the caller can commit the final step's sum on the same edge
  assign prod = acc + (mp[0] ? mc : '0);
  assign done = step && cnt == CW'(MUL_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || load) begin
      acc <= '0;
      mc <= rst ? '0 : {{(W-1){1'b0}}, ma};
      mp <= rst ? '0 : mb;
      cnt <= '0;
    end else if (step) begin
      acc <= prod;
      mc <= mc << 1;
      mp <= mp >> 1;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU feeding AC; single-cycle add/sub/logic/shift, W-cycle MUL with busy, registered z/flags and load_ac strobe
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  state_t state;
  logic sign, done, mul_go, commit, rv, nv;
  logic [W:0] ma, mb;
  logic [2*W-1:0] prod, p;
  logic [W-1:0] sum, dif, r, nz;
  // W+1-bit magnitudes so that -2^(W-1) is representable
  assign ma = bus.a[W-1] ? -{bus.a[W-1], bus.a} : {bus.a[W-1], bus.a};
  assign mb = bus.b[W-1] ? -{bus.b[W-1], bus.b} : {bus.b[W-1], bus.b};
  assign sum = bus.a + bus.b;
  assign dif = bus.a - bus.b;
  assign p = sign ? -prod : prod;
  assign mul_go = state == S_IDLE && bus.start && bus.op == OP_MUL;
  assign commit = state == S_IDLE ? bus.start && bus.op != OP_MUL : done;
  assign nz = state == S_MUL ? p[W-1:0] : r;
  // product overflows W bits unless the top W+1 bits are a pure sign extension
  assign nv = state == S_MUL ? ~(&p[2*W-1:W-1] | ~|p[2*W-1:W-1]) : rv;
  always_comb begin
    r = '0;
    rv = 1'b0;
    case (bus.op)
      OP_ADD: begin r = sum; rv = bus.a[W-1] == bus.b[W-1] && sum[W-1] != bus.a[W-1]; end
      OP_SUB: begin r = dif; rv = bus.a[W-1] != bus.b[W-1] && dif[W-1] != bus.a[W-1]; end
      OP_AND: r = bus.a & bus.b;
      OP_OR:  r = bus.a | bus.b;
      OP_XOR: r = bus.a ^ bus.b;
      OP_SHL: begin r = {bus.a[W-2:0], 1'b0}; rv = bus.a[W-1] ^ bus.a[W-2]; end
      OP_ASR: r = {bus.a[W-1], bus.a[W-1:1]};
      OP_MUL: r = '0;
    endcase
  end
  alu_seq_mul_iter u_mul (
    .clk(clk), .rst(reset), .load(mul_go), .step(state == S_MUL),
    .ma(ma), .mb(mb), .prod(prod), .done(done)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      sign <= 1'b0;
      bus.z <= '0;
      bus.load_ac <= 1'b0;
      bus.busy <= 1'b0;
      bus.n_f <= 1'b0;
      bus.zero_f <= 1'b0;
      bus.v_f <= 1'b0;
    end else begin
      bus.load_ac <= commit;
      if (commit) begin
        bus.z <= nz;
        bus.n_f <= nz[W-1];
        bus.zero_f <= nz == '0;
        bus.v_f <= nv;
      end
      if (mul_go) begin
        state <= S_MUL;
        bus.busy <= 1'b1;
        sign <= bus.a[W-1] ^ bus.b[W-1];
      end else if (done) begin
        state <= S_IDLE;
        bus.busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq; expected results queued at issue, compared whenever load_ac is seen
module tb_alu_seq;
  import alu_seq_pkg::*;
  typedef struct packed {logic [7:0] z; logic n; logic zr; logic v;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  alu_seq_if bus();
  alu_seq dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  exp_t sb[$];
  int errs = 0;
  int checks = 0;
  int la_cnt = 0;
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic exp_t model(op_t op, logic [7:0] a, logic [7:0] b);
    exp_t e;
    int ia, ib, rr;
    ia = int'($signed(a));
    ib = int'($signed(b));
    rr = 0;
    e.v = 1'b0;
    case (op)
      OP_ADD: rr = ia + ib;
      OP_SUB: rr = ia - ib;
      OP_AND: rr = int'(a & b);
      OP_OR:  rr = int'(a | b);
      OP_XOR: rr = int'(a ^ b);
      OP_SHL: rr = ia * 2;
      OP_ASR: rr = ia >>> 1;
      OP_MUL: rr = ia * ib;
    endcase
    if (op inside {OP_ADD, OP_SUB, OP_SHL, OP_MUL}) e.v = rr > 127 || rr < -128;
    e.z = rr[7:0];
    e.n = e.z[7];
    e.zr = e.z == 8'h00;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (bus.load_ac === 1'b1) begin
      la_cnt++;
      if (sb.size() == 0) chk("spurious_load_ac", 1, 0);
      else begin
        e = sb.pop_front();
        chk("z", bus.z, e.z);
        chk("n_f", bus.n_f, e.n);
        chk("zero_f", bus.zero_f, e.zr);
        chk("v_f", bus.v_f, e.v);
      end
    end
  end
  task automatic issue(op_t op, logic [7:0] a, logic [7:0] b, bit push);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    if (push) sb.push_back(model(op, a, b));
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    bus.start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // counts edges from the MUL start edge until load_ac shows; optionally fires an ADD mid-run
  task automatic wait_mul(string tag, int inj);
    int n;
    n = 0;
    while (bus.load_ac !== 1'b1 && n < 30) begin
      chk({tag, "_busy"}, bus.busy, 1);
      bus.start = (n == inj);
      if (n == inj) begin
        bus.op = OP_ADD;
        bus.a = 8'd1;
        bus.b = 8'd1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, n, MUL_CYCLES);
    chk({tag, "_busy_end"}, bus.busy, 0);
  endtask
  initial begin
    int la0;
    bus.start = 1'b0;
    bus.op = OP_ADD;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_z", bus.z, 0);
    chk("rst_load_ac", bus.load_ac, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_flags", {bus.n_f, bus.zero_f, bus.v_f}, 0);
    la0 = la_cnt;
    issue(OP_ADD, 8'd100, 8'd50, 1);
    chk("add_load_ac", bus.load_ac, 1);
    idle(1);
    chk("add_load_ac_drop", bus.load_ac, 0);
    chk("add_pulses", la_cnt - la0, 1);
    la0 = la_cnt;
    issue(OP_SUB, 8'h80, 8'd1, 1);
    chk("sub_load_ac", bus.load_ac, 1);
    issue(OP_AND, 8'h0F, 8'hF0, 1);
    chk("and_load_ac", bus.load_ac, 1);
    idle(1);
    chk("b2b_drop", bus.load_ac, 0);
    chk("b2b_pulses", la_cnt - la0, 2);
    la0 = la_cnt;
    issue(OP_MUL, -8'sd7, 8'd9, 1);
    wait_mul("mul1", 2);
    idle(3);
    chk("mul1_pulses", la_cnt - la0, 1);
    issue(OP_MUL, 8'd12, -8'sd11, 1);
    wait_mul("mul2", -1);
    idle(1);
    issue(OP_MUL, 8'h80, 8'h80, 1);
    wait_mul("mul3", -1);
    idle(1);
    la0 = la_cnt;
    issue(OP_MUL, 8'd5, 8'd3, 0);
    idle(3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_load_ac", bus.load_ac, 0);
    chk("abort_z", bus.z, 0);
    chk("abort_flags", {bus.n_f, bus.zero_f, bus.v_f}, 0);
    idle(10);
    chk("abort_pulses", la_cnt - la0, 0);
    issue(OP_ADD, 8'd1, 8'd1, 1);
    idle(1);
    chk("post_abort_z", bus.z, 2);
    la0 = la_cnt;
    reset = 1'b1;
    issue(OP_ADD, 8'd3, 8'd4, 0);
    reset = 1'b0;
    chk("rst_start_load_ac", bus.load_ac, 0);
    chk("rst_start_z", bus.z, 0);
    idle(1);
    chk("rst_start_pulses", la_cnt - la0, 0);
    issue(OP_SHL, 8'h40, 8'hAA, 1);
    issue(OP_ASR, 8'h81, 8'h55, 1);
    issue(OP_XOR, 8'hA5, 8'h0F, 1);
    issue(OP_OR, 8'h00, 8'h00, 1);
    idle(2);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
